// File: rtl/rs_iss_sel.sv
// rs_iss_sel: issue-select stage behind the reservation station.
// Each cycle it picks at most one ready RS entry and returns a one-hot grant.
// The picked entry's payload is captured into a one-deep issue register that feeds one FU.
// The issue register honours FU back-pressure and is squashed by a matching branch recovery.
// Build option: define ISS_RR_EN for rotating priority that starts at a pointer.
// Without it, the lowest ready index always wins and no pointer register is built.
module rs_iss_sel #(
    parameter int RS_NUM    = 16,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter int BR_MASK_W = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [RS_NUM-1:0]                 ent_rdy_i,
    input  logic [RS_NUM*PRF_IDX_W-1:0]       ent_opa_tag_i,
    input  logic [RS_NUM*PRF_IDX_W-1:0]       ent_opb_tag_i,
    input  logic [RS_NUM*PRF_IDX_W-1:0]       ent_dest_tag_i,
    input  logic [RS_NUM*32-1:0]              ent_IR_i,
    input  logic [RS_NUM*(ROB_IDX_W+1)-1:0]   ent_rob_idx_i,
    input  logic [RS_NUM*BR_MASK_W-1:0]       ent_br_mask_i,
    input  logic                              fu_stall_i,
    input  logic                              br_recovery_i,
    input  logic                              br_pred_correct_i,
    input  logic [BR_MASK_W-1:0]              br_tag_fix_i,
    output logic [RS_NUM-1:0]                 iss_en_o,
    output logic                              iss_vld_o,
    output logic [PRF_IDX_W-1:0]              iss_opa_tag_o,
    output logic [PRF_IDX_W-1:0]              iss_opb_tag_o,
    output logic [PRF_IDX_W-1:0]              iss_dest_tag_o,
    output logic [31:0]                       iss_IR_o,
    output logic [ROB_IDX_W:0]                iss_rob_idx_o,
    output logic [BR_MASK_W-1:0]              iss_br_mask_o
);

    localparam int PTR_W = $clog2(RS_NUM);

    logic [PRF_IDX_W-1:0] opa_arr  [RS_NUM];
    logic [PRF_IDX_W-1:0] opb_arr  [RS_NUM];
    logic [PRF_IDX_W-1:0] dest_arr [RS_NUM];
    logic [31:0]          ir_arr   [RS_NUM];
    logic [ROB_IDX_W:0]   rob_arr  [RS_NUM];
    logic [BR_MASK_W-1:0] bm_arr   [RS_NUM];

    logic                 vld_r;
    logic [PRF_IDX_W-1:0] opa_r;
    logic [PRF_IDX_W-1:0] opb_r;
    logic [PRF_IDX_W-1:0] dest_r;
    logic [31:0]          ir_r;
    logic [ROB_IDX_W:0]   rob_r;
    logic [BR_MASK_W-1:0] br_mask_r;

    logic [BR_MASK_W-1:0] fix_clr;
    logic                 squash;
    logic                 can_take;
    logic                 found;
    logic                 grant;
    logic [PTR_W-1:0]     sel;

    // Unpack the flattened per-entry buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < RS_NUM; i++) begin
            opa_arr[i]  = ent_opa_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
            opb_arr[i]  = ent_opb_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
            dest_arr[i] = ent_dest_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
            ir_arr[i]   = ent_IR_i[i*32 +: 32];
            rob_arr[i]  = ent_rob_idx_i[i*(ROB_IDX_W+1) +: (ROB_IDX_W+1)];
            bm_arr[i]   = ent_br_mask_i[i*BR_MASK_W +: BR_MASK_W];
        end
    end

    // Squash only when the recovering branch is one the held op depends on.
    // A squashed register can always accept, but a recovery cycle never grants.
    always_comb begin
        fix_clr  = br_pred_correct_i ? br_tag_fix_i : '0;
        squash   = br_recovery_i & (|(br_tag_fix_i & br_mask_r));
        can_take = ~vld_r | ~fu_stall_i | squash;
        grant    = can_take & ~br_recovery_i & found & ~rst;
    end

`ifdef ISS_RR_EN
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] rr_idx;

    // Rotating search: first ready entry at or above ptr, wrapping past the top.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        rr_idx = '0;
        for (int i = 0; i < RS_NUM; i++) begin
            rr_idx = ptr + PTR_W'(i);
            if (!found && ent_rdy_i[rr_idx]) begin
                found = 1'b1;
                sel   = rr_idx;
            end
        end
    end

    // Advance the pointer one past the granted entry; power-of-2 size wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= sel + PTR_W'(1);
        end
    end
`else
    // Fixed priority: lowest ready index wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < RS_NUM; i++) begin
            if (!found && ent_rdy_i[i]) begin
                found = 1'b1;
                sel   = PTR_W'(i);
            end
        end
    end
`endif

    // One-hot grant back to the chosen entry.
    always_comb begin
        iss_en_o      = '0;
        iss_en_o[sel] = grant;
    end

    // Issue register: squash beats stall-hold, which beats a new load.
    // A resolving-correct branch clears its mask bit in every case.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r     <= 1'b0;
            opa_r     <= '0;
            opb_r     <= '0;
            dest_r    <= '0;
            ir_r      <= '0;
            rob_r     <= '0;
            br_mask_r <= '0;
        end else begin
            br_mask_r <= br_mask_r & ~fix_clr;
            if (squash) begin
                vld_r <= 1'b0;
            end else if (vld_r && fu_stall_i) begin
                vld_r <= 1'b1;
            end else if (grant) begin
                vld_r     <= 1'b1;
                opa_r     <= opa_arr[sel];
                opb_r     <= opb_arr[sel];
                dest_r    <= dest_arr[sel];
                ir_r      <= ir_arr[sel];
                rob_r     <= rob_arr[sel];
                br_mask_r <= bm_arr[sel] & ~fix_clr;
            end else begin
                vld_r <= 1'b0;
            end
        end
    end

    // The mask seen downstream already has this cycle's correct-resolution applied.
    always_comb begin
        iss_vld_o      = vld_r;
        iss_opa_tag_o  = opa_r;
        iss_opb_tag_o  = opb_r;
        iss_dest_tag_o = dest_r;
        iss_IR_o       = ir_r;
        iss_rob_idx_o  = rob_r;
        iss_br_mask_o  = br_mask_r & ~fix_clr;
    end

endmodule

// File: tb/tb_rs_iss_sel.sv
// tb_rs_iss_sel: directed checks of grant selection, issue latching, stall hold,
// branch squash/correct-clear and reset for rs_iss_sel.
module tb_rs_iss_sel;

    localparam int N = 16;
    localparam int P = 6;
    localparam int R = 5;
    localparam int B = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       ent_rdy_i;
    logic [N*P-1:0]     ent_opa_tag_i;
    logic [N*P-1:0]     ent_opb_tag_i;
    logic [N*P-1:0]     ent_dest_tag_i;
    logic [N*32-1:0]    ent_IR_i;
    logic [N*(R+1)-1:0] ent_rob_idx_i;
    logic [N*B-1:0]     ent_br_mask_i;
    logic               fu_stall_i;
    logic               br_recovery_i;
    logic               br_pred_correct_i;
    logic [B-1:0]       br_tag_fix_i;
    logic [N-1:0]       iss_en_o;
    logic               iss_vld_o;
    logic [P-1:0]       iss_opa_tag_o;
    logic [P-1:0]       iss_opb_tag_o;
    logic [P-1:0]       iss_dest_tag_o;
    logic [31:0]        iss_IR_o;
    logic [R:0]         iss_rob_idx_o;
    logic [B-1:0]       iss_br_mask_o;

    int total = 0;
    int bad   = 0;

`ifdef ISS_RR_EN
    localparam logic [15:0] G3 [4] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
    localparam logic [5:0]  LAST_OPA = 6'd15;
`else
    localparam logic [15:0] G3 [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    localparam logic [5:0]  LAST_OPA = 6'd0;
`endif

    rs_iss_sel #(.RS_NUM(N), .PRF_IDX_W(P), .ROB_IDX_W(R), .BR_MASK_W(B)) dut (
        .clk               (clk),
        .rst               (rst),
        .ent_rdy_i         (ent_rdy_i),
        .ent_opa_tag_i     (ent_opa_tag_i),
        .ent_opb_tag_i     (ent_opb_tag_i),
        .ent_dest_tag_i    (ent_dest_tag_i),
        .ent_IR_i          (ent_IR_i),
        .ent_rob_idx_i     (ent_rob_idx_i),
        .ent_br_mask_i     (ent_br_mask_i),
        .fu_stall_i        (fu_stall_i),
        .br_recovery_i     (br_recovery_i),
        .br_pred_correct_i (br_pred_correct_i),
        .br_tag_fix_i      (br_tag_fix_i),
        .iss_en_o          (iss_en_o),
        .iss_vld_o         (iss_vld_o),
        .iss_opa_tag_o     (iss_opa_tag_o),
        .iss_opb_tag_o     (iss_opb_tag_o),
        .iss_dest_tag_o    (iss_dest_tag_o),
        .iss_IR_o          (iss_IR_o),
        .iss_rob_idx_o     (iss_rob_idx_o),
        .iss_br_mask_o     (iss_br_mask_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] exp_idx;
        // Entry k: opA=k, opB=k+16, dest=k+32 (entry 4: 6'h21), IR=C0DE_000k, rob=2k+1,
        // mask 5'b00001 except entry 1 = 5'b00110 and entry 4 = 5'b00100.
        for (int k = 0; k < N; k++) begin
            ent_opa_tag_i[k*P +: P]       = 6'(k);
            ent_opb_tag_i[k*P +: P]       = 6'(k + 16);
            ent_dest_tag_i[k*P +: P]      = 6'(k + 32);
            ent_IR_i[k*32 +: 32]          = 32'hC0DE_0000 + 32'(k);
            ent_rob_idx_i[k*(R+1) +: R+1] = 6'(2*k + 1);
            ent_br_mask_i[k*B +: B]       = 5'b00001;
        end
        ent_dest_tag_i[4*P +: P] = 6'h21;
        ent_br_mask_i[1*B +: B]  = 5'b00110;
        ent_br_mask_i[4*B +: B]  = 5'b00100;

        rst = 1'b1; ent_rdy_i = 16'h0090; fu_stall_i = 1'b0;
        br_recovery_i = 1'b0; br_pred_correct_i = 1'b0; br_tag_fix_i = '0;
        #1;
        chk("en_during_rst", 32'(iss_en_o), 32'h0);
        cyc(); cyc();

        // Reset state
        rst = 1'b0; ent_rdy_i = '0;
        #1;
        chk("rst_en",   32'(iss_en_o), 32'h0);
        chk("rst_vld",  32'(iss_vld_o), 32'h0);
        chk("rst_opa",  32'(iss_opa_tag_o), 32'h0);
        chk("rst_opb",  32'(iss_opb_tag_o), 32'h0);
        chk("rst_dest", 32'(iss_dest_tag_o), 32'h0);
        chk("rst_ir",   iss_IR_o, 32'h0);
        chk("rst_rob",  32'(iss_rob_idx_o), 32'h0);
        chk("rst_mask", 32'(iss_br_mask_o), 32'h0);

        // Lowest ready of 0x0090 is entry 4
        ent_rdy_i = 16'h0090;
        #1;
        chk("sel4_en", 32'(iss_en_o), 32'h0010);
        cyc();
        ent_rdy_i = 16'h0080;
        #1;
        chk("sel4_vld",  32'(iss_vld_o), 32'h1);
        chk("sel4_dest", 32'(iss_dest_tag_o), 32'h21);
        chk("sel4_opa",  32'(iss_opa_tag_o), 32'h04);
        chk("sel4_opb",  32'(iss_opb_tag_o), 32'h14);
        chk("sel4_ir",   iss_IR_o, 32'hC0DE_0004);
        chk("sel4_rob",  32'(iss_rob_idx_o), 32'h09);
        chk("sel4_mask", 32'(iss_br_mask_o), 32'h04);
        chk("sel7_en",   32'(iss_en_o), 32'h0080);
        cyc();

        // Reset again so the rotating pointer restarts at 0
        rst = 1'b1; ent_rdy_i = '0;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst2_vld", 32'(iss_vld_o), 32'h0);

        // Both ends ready for four cycles
        for (int i = 0; i < 4; i++) begin
            ent_rdy_i = 16'h8001;
            #1;
            chk("pair_en", 32'(iss_en_o), 32'(G3[i]));
            cyc();
            exp_idx = G3[i][15] ? 6'd15 : 6'd0;
            chk("pair_opa", 32'(iss_opa_tag_o), 32'(exp_idx));
        end

        // Stall holds everything for three cycles, then grant on release
        fu_stall_i = 1'b1; ent_rdy_i = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_en",  32'(iss_en_o), 32'h0);
            chk("stall_opa", 32'(iss_opa_tag_o), 32'(LAST_OPA));
            chk("stall_vld", 32'(iss_vld_o), 32'h1);
            cyc();
        end
        fu_stall_i = 1'b0;
        #1;
        chk("unstall_en", 32'(iss_en_o), 32'h0002);
        cyc();
        chk("ent1_opa",  32'(iss_opa_tag_o), 32'h01);
        chk("ent1_mask", 32'(iss_br_mask_o), 32'h06);

        // Correct-resolution clears mask bit combinationally and in the register
        ent_rdy_i = '0; fu_stall_i = 1'b1; br_pred_correct_i = 1'b1; br_tag_fix_i = 5'b00010;
        #1;
        chk("corr_mask_comb", 32'(iss_br_mask_o), 32'h04);
        chk("corr_en",        32'(iss_en_o), 32'h0);
        cyc();
        br_pred_correct_i = 1'b0; br_tag_fix_i = '0;
        #1;
        chk("corr_mask_reg", 32'(iss_br_mask_o), 32'h04);
        chk("corr_vld",      32'(iss_vld_o), 32'h1);

        // Recovery on an unrelated branch: no grant, stalled op survives
        br_recovery_i = 1'b1; br_tag_fix_i = 5'b00001; ent_rdy_i = 16'h0002;
        #1;
        chk("rec_nomatch_en", 32'(iss_en_o), 32'h0);
        cyc();
        chk("rec_nomatch_vld", 32'(iss_vld_o), 32'h1);

        // Matching recovery squashes even while stalled
        br_tag_fix_i = 5'b00100;
        #1;
        chk("squash_en", 32'(iss_en_o), 32'h0);
        cyc();
        br_recovery_i = 1'b0; br_tag_fix_i = '0;
        #1;
        chk("squash_vld", 32'(iss_vld_o), 32'h0);

        // Load with a simultaneous correct-resolution: loaded mask is cleared
        fu_stall_i = 1'b0; ent_rdy_i = 16'h0002; br_pred_correct_i = 1'b1; br_tag_fix_i = 5'b00100;
        #1;
        chk("ldclr_en",   32'(iss_en_o), 32'h0002);
        chk("ldclr_comb", 32'(iss_br_mask_o), 32'h00);
        cyc();
        br_pred_correct_i = 1'b0; br_tag_fix_i = '0; ent_rdy_i = '0;
        #1;
        chk("ldclr_vld",  32'(iss_vld_o), 32'h1);
        chk("ldclr_mask", 32'(iss_br_mask_o), 32'h02);

        // Recovery and correct together: recovery wins for valid, clear still applies
        br_recovery_i = 1'b1; br_pred_correct_i = 1'b1; br_tag_fix_i = 5'b00010;
        #1;
        chk("both_mask_comb", 32'(iss_br_mask_o), 32'h00);
        chk("both_en",        32'(iss_en_o), 32'h0);
        cyc();
        br_recovery_i = 1'b0; br_pred_correct_i = 1'b0; br_tag_fix_i = '0;
        #1;
        chk("both_vld",  32'(iss_vld_o), 32'h0);
        chk("both_mask", 32'(iss_br_mask_o), 32'h00);

        // With nothing ready and no stall, valid drops after one cycle
        ent_rdy_i = 16'h0002;
        #1;
        chk("idle_en", 32'(iss_en_o), 32'h0002);
        cyc();
        ent_rdy_i = '0;
        #1;
        chk("idle_vld1", 32'(iss_vld_o), 32'h1);
        cyc();
        chk("idle_drop", 32'(iss_vld_o), 32'h0);

        // Reset during a stall clears everything
        ent_rdy_i = 16'h0002;
        cyc();
        chk("pre_rst_vld", 32'(iss_vld_o), 32'h1);
        fu_stall_i = 1'b1; rst = 1'b1;
        #1;
        chk("rst_stall_en", 32'(iss_en_o), 32'h0);
        cyc();
        rst = 1'b0; fu_stall_i = 1'b0; ent_rdy_i = '0;
        #1;
        chk("rst_stall_vld",  32'(iss_vld_o), 32'h0);
        chk("rst_stall_opa",  32'(iss_opa_tag_o), 32'h0);
        chk("rst_stall_mask", 32'(iss_br_mask_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
